// File: rtl/prim_shadow_wr_ctrl_pkg.sv
// Shared types for the shadowed-register write controller: sequence states,
// completion status codes and the status priority resolver.
package prim_shadow_wr_ctrl_pkg;

  localparam int StatusW = 2;

  // Sequence states: grant in IDLE, then phase-clear read, staging write,
  // commit write, error check and a one-cycle response.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    WR1  = 3'd2,
    WR2  = 3'd3,
    CHK  = 3'd4,
    RSP  = 3'd5
  } shadow_wr_state_e;

  typedef enum logic [StatusW-1:0] {
    STATUS_OK          = 2'd0,
    STATUS_ERR_UPDATE  = 2'd1,
    STATUS_ERR_STORAGE = 2'd2,
    STATUS_ERR_PHASE   = 2'd3
  } shadow_wr_status_e;

  // Storage errors dominate, then update errors, then a wrong phase. A
  // readback mismatch only shows up when nothing else went wrong.
  function automatic shadow_wr_status_e shadow_wr_resolve(input logic sto_err,
                                                          input logic upd_err,
                                                          input logic phase_err,
                                                          input logic rb_err);
    shadow_wr_status_e res;
    if (sto_err)        res = STATUS_ERR_STORAGE;
    else if (upd_err)   res = STATUS_ERR_UPDATE;
    else if (phase_err) res = STATUS_ERR_PHASE;
    else if (rb_err)    res = STATUS_ERR_UPDATE;
    else                res = STATUS_OK;
    return res;
  endfunction

endpackage

// File: rtl/prim_shadow_wr_rr_arb.sv
// Combinational round-robin arbiter: scans the request vector starting at
// the pointer position and returns a one-hot grant (all zero if no request).
module prim_shadow_wr_rr_arb
  import prim_shadow_wr_ctrl_pkg::*;
#(
  parameter int  N    = 4,
  localparam int PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [PtrW-1:0] ptr,
  output logic [N-1:0]    gnt
);

  // First requester at or after the pointer, wrapping modulo N.
  always_comb begin
    int   j;
    logic found;
    gnt   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prim_shadow_wr_ctrl.sv
// Shadowed-register write controller. Arbitrates NumReq requesters and turns
// each granted write into: phase-clear read, staging write, commit write,
// error check, response. Optional build macro PRIM_SHADOW_WR_CTRL_READBACK_EN
// adds a committed-value comparison in the check cycle.
//
// Handshake: a requester raises req_i with index and data and holds all three
// until it sees its one-cycle ack_o pulse; status_o is valid only in that
// cycle. Values are latched at grant, so later changes are ignored.
module prim_shadow_wr_ctrl
  import prim_shadow_wr_ctrl_pkg::*;
#(
  parameter int  NumReq  = 4,
  parameter int  NumRegs = 8,
  parameter int  DW      = 32,
  localparam int RegIdxW = (NumRegs > 1) ? $clog2(NumRegs) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumReq-1:0]         req_i,
  input  logic [NumReq*RegIdxW-1:0] req_idx_i,
  input  logic [NumReq*DW-1:0]      req_data_i,
  output logic [NumReq-1:0]         ack_o,
  output logic [StatusW-1:0]        status_o,
  output logic                      busy_o,
  output logic [NumRegs-1:0]        reg_sel_o,
  output logic                      reg_re_o,
  output logic                      reg_we_o,
  output logic [DW-1:0]             reg_wd_o,
  input  logic [NumRegs-1:0]        reg_phase_i,
  input  logic [NumRegs-1:0]        reg_err_update_i,
  input  logic [NumRegs-1:0]        reg_err_storage_i,
  input  logic [NumRegs*DW-1:0]     reg_q_i
);

  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  shadow_wr_state_e  state_q;
  shadow_wr_status_e status_q;
  logic [PtrW-1:0]    ptr_q;
  logic [PtrW-1:0]    gnt_idx_q;
  logic [PtrW-1:0]    gnt_idx;
  logic [NumReq-1:0]  gnt_q;
  logic [NumReq-1:0]  gnt;
  logic [NumReq-1:0]  arb_req;
  logic [RegIdxW-1:0] idx_q;
  logic [RegIdxW-1:0] g_idx;
  logic [DW-1:0]      data_q;
  logic [DW-1:0]      g_data;
  logic               idx_ok_q;
  logic               g_ok;
  logic               upd_err_q;
  logic               phase_err_q;
  logic [NumRegs-1:0] sel_vec;
  logic               in_seq;
  logic               rb_mismatch;

  // Arbitration only happens in IDLE; a requester being acked is never a
  // candidate in the same cycle.
  assign arb_req = (state_q == IDLE) ? (req_i & ~ack_o) : '0;

  prim_shadow_wr_rr_arb #(
    .N (NumReq)
  ) u_arb (
    .req (arb_req),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  // Pick the granted requester's index and data out of the flat buses.
  always_comb begin
    gnt_idx = '0;
    g_idx   = '0;
    g_data  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (gnt[i]) begin
        gnt_idx = PtrW'(i);
        g_idx   = req_idx_i[i*RegIdxW +: RegIdxW];
        g_data  = req_data_i[i*DW +: DW];
      end
    end
  end

  assign g_ok = (int'(g_idx) < NumRegs);

  // One-hot register select from the latched index; empty when out of range.
  always_comb begin
    sel_vec = '0;
    for (int r = 0; r < NumRegs; r++) begin
      if (idx_ok_q && (idx_q == RegIdxW'(r))) sel_vec[r] = 1'b1;
    end
  end

`ifdef PRIM_SHADOW_WR_CTRL_READBACK_EN
  logic [DW-1:0] sel_q;

  // Committed value of the selected register, compared against the intent.
  always_comb begin
    sel_q = '0;
    for (int r = 0; r < NumRegs; r++) begin
      if (sel_vec[r]) sel_q = reg_q_i[r*DW +: DW];
    end
  end

  assign rb_mismatch = (|sel_vec) && (sel_q != data_q);
`else
  logic unused_reg_q;
  assign unused_reg_q = ^reg_q_i;
  assign rb_mismatch  = 1'b0;
`endif

  // Sequence FSM with latched grant, error sampling and pointer update.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      status_q    <= STATUS_OK;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      idx_ok_q    <= 1'b0;
      upd_err_q   <= 1'b0;
      phase_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|gnt) begin
            gnt_q       <= gnt;
            gnt_idx_q   <= gnt_idx;
            idx_q       <= g_idx;
            data_q      <= g_data;
            idx_ok_q    <= g_ok;
            upd_err_q   <= 1'b0;
            phase_err_q <= 1'b0;
            if (g_ok) begin
              state_q <= CLR;
            end else begin
              // Nothing to address: answer immediately without strobes.
              status_q <= STATUS_ERR_PHASE;
              state_q  <= RSP;
            end
          end
        end
        CLR: state_q <= WR1;
        WR1: state_q <= WR2;
        WR2: begin
          // After the staging write the phase bit must be set.
          upd_err_q   <= |(reg_err_update_i & sel_vec);
          phase_err_q <= ~|(reg_phase_i & sel_vec);
          state_q     <= CHK;
        end
        CHK: begin
          status_q <= shadow_wr_resolve(|(reg_err_storage_i & sel_vec),
                                        upd_err_q, phase_err_q, rb_mismatch);
          state_q  <= RSP;
        end
        RSP: begin
          ptr_q   <= (gnt_idx_q == PtrW'(NumReq - 1)) ? '0 : gnt_idx_q + 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output decode straight from the state register.
  assign in_seq    = (state_q == CLR) || (state_q == WR1) ||
                     (state_q == WR2) || (state_q == CHK);
  assign busy_o    = (state_q != IDLE);
  assign reg_sel_o = in_seq ? sel_vec : '0;
  assign reg_re_o  = (state_q == CLR);
  assign reg_we_o  = (state_q == WR1) || (state_q == WR2);
  assign reg_wd_o  = data_q;
  assign ack_o     = (state_q == RSP) ? gnt_q : '0;
  assign status_o  = (state_q == RSP) ? status_q : STATUS_OK;

endmodule
